uart_cmd_framer: RTL and testbench



---
 rtl/cmd_pkg.sv | 10 +
 rtl/cmd_gap_timer.sv | 17 +
 rtl/uart_cmd_framer.sv | 117 +++++++++++
 tb/tb_uart_cmd_framer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared types and constants for the UART command framer.
package cmd_pkg;
   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, WRITE} state_t;
   localparam logic [1:0] ERR_CHK = 2'd0;
   localparam logic [1:0] ERR_TMO = 2'd1;
   localparam logic [1:0] ERR_OVF = 2'd2;
   localparam logic [7:0] SYNC_DEF = 8'hA5;
   localparam int CMD_W = 32;
   localparam int CMD_BYTES = 4;
endpackage

// File: rtl/cmd_gap_timer.sv
// cmd_gap_timer: inter-byte gap counter; clr reloads to 0, expire pulses when LIMIT-1 is reached while enabled.
module cmd_gap_timer #(
   parameter int unsigned LIMIT = 4800
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   assign expire = en && !clr && cnt == W'(LIMIT - 1);
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (clr || !en || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: finds SYNC, assembles a 4-byte little-endian command and writes it to the FIFO.
// Define UART_CMD_FRAMER_CHK_EN to require and verify the trailing XOR checksum byte.
module uart_cmd_framer
   import cmd_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 24000000,
   parameter int unsigned TIMEOUT_US = 200,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_DEF
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             fifo_full,
   output logic             fifo_wrreq,
   output logic [CMD_W-1:0] fifo_data,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic [7:0]       err_cnt,
   output logic             busy
);
   localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
   state_t state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [CMD_W-1:0] sh, sh_nxt;
   logic wr_nxt, err_nxt, expire;
   logic [1:0] code_nxt;
   cmd_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap (
      .CLK(CLK), .reset_n(reset_n), .clr(rx_valid),
      .en(state == PAYLOAD || state == CHECK), .expire(expire)
   );
`ifdef UART_CMD_FRAMER_CHK_EN
   logic [7:0] chk;
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) chk <= '0;
      else if (state == IDLE) chk <= SYNC_BYTE;
      else if (state == PAYLOAD && rx_valid) chk <= chk ^ rx_data;
`endif
   assign busy = state != IDLE;
   always_comb begin
      state_nxt = state;
      idx_nxt = idx;
      sh_nxt = sh;
      wr_nxt = 1'b0;
      err_nxt = 1'b0;
      code_nxt = ERR_CHK;
      case (state)
         IDLE:
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_nxt = PAYLOAD;
               idx_nxt = '0;
            end
         PAYLOAD:
            if (rx_valid) begin
               sh_nxt = {rx_data, sh[CMD_W-1:8]};
               idx_nxt = idx + 2'd1;
               if (idx == 2'(CMD_BYTES - 1)) begin
`ifdef UART_CMD_FRAMER_CHK_EN
                  state_nxt = CHECK;
`else
                  state_nxt = fifo_full ? IDLE : WRITE;
                  err_nxt = fifo_full;
                  code_nxt = ERR_OVF;
`endif
               end
            end else if (expire) begin
               state_nxt = IDLE;
               err_nxt = 1'b1;
               code_nxt = ERR_TMO;
            end
         CHECK: begin
`ifdef UART_CMD_FRAMER_CHK_EN
            if (rx_valid) begin
               state_nxt = (rx_data == chk && !fifo_full) ? WRITE : IDLE;
               err_nxt = rx_data != chk || fifo_full;
               code_nxt = rx_data != chk ? ERR_CHK : ERR_OVF;
            end else if (expire) begin
               state_nxt = IDLE;
               err_nxt = 1'b1;
               code_nxt = ERR_TMO;
            end
`else
            state_nxt = IDLE;
`endif
         end
         WRITE: begin
            wr_nxt = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         idx <= '0;
         sh <= '0;
         fifo_wrreq <= 1'b0;
         frame_ok <= 1'b0;
         fifo_data <= '0;
         frame_err <= 1'b0;
         err_code <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         idx <= idx_nxt;
         sh <= sh_nxt;
         fifo_wrreq <= wr_nxt;
         frame_ok <= wr_nxt;
         frame_err <= err_nxt;
         if (wr_nxt) fifo_data <= sh;
         if (err_nxt) begin
            err_code <= code_nxt;
            err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
         end
      end
endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: table-driven frames plus timeout, overflow-saturation and reset sequences, scoreboarded.
module tb_uart_cmd_framer;
`ifdef UART_CMD_FRAMER_CHK_EN
   localparam bit HAS_CHK = 1'b1;
`else
   localparam bit HAS_CHK = 1'b0;
`endif
   logic CLK = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, fifo_full = 1'b0;
   logic [7:0] rx_data = '0;
   logic fifo_wrreq, frame_ok, frame_err, busy;
   logic [31:0] fifo_data;
   logic [1:0] err_code;
   logic [7:0] err_cnt;
   int total = 0, passed = 0, errs = 0;
   logic [31:0] last_word = '0;
   typedef struct {logic is_err; logic [1:0] code; logic [31:0] word;} exp_t;
   exp_t q[$];
   typedef struct {logic junk; logic [31:0] word; logic bad; logic full; logic exp_err; logic [1:0] exp_code;} vec_t;
   vec_t vecs[6];

   uart_cmd_framer dut (
      .CLK(CLK), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
      .err_cnt(err_cnt), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   always @(negedge CLK)
      if (fifo_wrreq || frame_err) begin
         if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected: wrreq=%b frame_err=%b code=%0d data=%h expected nothing", fifo_wrreq, frame_err, err_code, fifo_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("kind", {30'd0, frame_err, fifo_wrreq}, e.is_err ? 32'd2 : 32'd1);
            if (e.is_err) check("err_code", {30'd0, err_code}, {30'd0, e.code});
            else begin
               check("fifo_data", fifo_data, e.word);
               check("frame_ok", {31'd0, frame_ok}, 32'd1);
            end
         end
      end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      rx_valid = 1'b1;
      rx_data = b;
      @(negedge CLK);
      rx_valid = 1'b0;
      @(negedge CLK);
   endtask

   task automatic send_frame(input logic [31:0] w, input logic bad);
      logic [7:0] c;
      c = 8'hA5 ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
      if (HAS_CHK) send_byte(bad ? 8'h00 : c);
   endtask

   task automatic expect_ev(input logic is_err, input logic [1:0] code, input logic [31:0] w);
      exp_t e;
      e.is_err = is_err;
      e.code = code;
      e.word = w;
      q.push_back(e);
      if (is_err) errs++;
      else last_word = w;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) @(negedge CLK);
      check("pending", q.size(), 0);
      q.delete();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_err_cnt"}, {24'd0, err_cnt}, errs > 255 ? 32'd255 : errs);
      check({tag, "_fifo_data"}, fifo_data, last_word);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h44332211, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[1] = '{1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[2] = '{1'b0, 32'h44332211, 1'b1, 1'b0, HAS_CHK, 2'd0};
      vecs[3] = '{1'b0, 32'hA5A50F5A, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[4] = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[5] = '{1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 2'd0};
      repeat (3) @(negedge CLK);
      reset_n = 1'b1;
      @(negedge CLK);
      check("rst_outputs", {fifo_wrreq, frame_ok, frame_err, busy, err_code, err_cnt}, 0);
      check("rst_data", fifo_data, 0);
      for (int i = 0; i < 6; i++) begin
         fifo_full = vecs[i].full;
         if (vecs[i].junk) begin
            send_byte(8'h00);
            send_byte(8'hFF);
         end
         expect_ev(vecs[i].exp_err, vecs[i].exp_code, vecs[i].word);
         send_frame(vecs[i].word, vecs[i].bad);
         drain(8);
         fifo_full = 1'b0;
         check_state($sformatf("vec%0d", i));
      end
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (4700) @(negedge CLK);
      check("tmo_busy", {31'd0, busy}, 32'd1);
      expect_ev(1'b1, 2'd1, 32'h0);
      drain(200);
      check("tmo_idle", {31'd0, busy}, 32'd0);
      expect_ev(1'b0, 2'd0, 32'hCAFE0042);
      send_frame(32'hCAFE0042, 1'b0);
      drain(8);
      check_state("tmo");
      fifo_full = 1'b1;
      for (int i = 0; i < 300; i++) begin
         expect_ev(1'b1, 2'd2, 32'h0);
         send_frame(32'h12345678 + i, 1'b0);
         drain(8);
      end
      fifo_full = 1'b0;
      check_state("sat");
      send_byte(8'hA5);
      send_byte(8'h11);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      @(negedge CLK);
      reset_n = 1'b0;
      @(negedge CLK);
      errs = 0;
      last_word = '0;
      check("midrst_outputs", {fifo_wrreq, frame_ok, frame_err, busy, err_code, err_cnt}, 0);
      check("midrst_data", fifo_data, 0);
      reset_n = 1'b1;
      expect_ev(1'b0, 2'd0, 32'h0BADF00D);
      send_frame(32'h0BADF00D, 1'b0);
      drain(8);
      check_state("post_rst");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
